// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU micro-sequencer: FSM states, ALU
// select encodings, command kinds and the keypad timeout counter width.
package alu_seq_pkg;

    localparam int KT_W = 24;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic CMD_ALU  = 1'b0;
    localparam logic CMD_LOAD = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WRITE,
        S_WAIT_KEY,
        S_LOAD,
        S_DONE
    } state_t;

endpackage

// File: rtl/seq_timeout_cnt.sv
// Clearable up-counter that flags the last cycle of the keypad wait window.
// A KEY_TIMEOUT of zero means the window never expires.
module seq_timeout_cnt
    import alu_seq_pkg::*;
#(
    parameter logic [KT_W-1:0] KEY_TIMEOUT = 24'd10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [KT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (KEY_TIMEOUT != '0) && (count == KEY_TIMEOUT - 1'b1);

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven sequencer for the 4x8 register bank and 2-bit ALU: runs
// chained ALU ops with repeat, or loads a keypad code into a register.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter logic [KT_W-1:0] KEY_TIMEOUT = 24'd10_000_000,
    parameter int              REP_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_kind,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_src_a,
    input  logic [1:0]       cmd_src_b,
    input  logic [1:0]       cmd_dst,
    input  logic [REP_W-1:0] cmd_rep,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [1:0]       reg_addr_a,
    output logic [1:0]       reg_addr_b,
    output logic [1:0]       reg_addr_wr,
    output logic [7:0]       reg_wr_data,
    output logic             reg_wr_en,
    input  logic [7:0]       reg_dout_a,
    input  logic [7:0]       reg_dout_b,
    output logic [1:0]       alu_sel,
    input  logic [7:0]       alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             flag_zero,
    output logic             flag_carry
);

    state_t           state;
    logic [1:0]       op_q;
    logic [1:0]       src_b_q;
    logic [1:0]       dst_q;
    logic [REP_W-1:0] rep_cnt;
    logic             key_expired;

    // Bank read data reaches the sequencer only through the ALU.
    logic unused_dout;
    assign unused_dout = ^{reg_dout_a, reg_dout_b};

    seq_timeout_cnt #(
        .KEY_TIMEOUT(KEY_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == S_IDLE),
        .enable (state == S_WAIT_KEY),
        .expired(key_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= OP_ADD;
            src_b_q     <= '0;
            dst_q       <= '0;
            rep_cnt     <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            flag_zero   <= 1'b0;
            flag_carry  <= 1'b0;
            reg_addr_a  <= '0;
            reg_addr_b  <= '0;
            reg_addr_wr <= '0;
            reg_wr_data <= '0;
            reg_wr_en   <= 1'b0;
            alu_sel     <= OP_ADD;
        end else begin
            // NOTE: outputs are registered alongside the next state; these
            // defaults hold for the coming cycle unless the transition below
            // overrides them, and non-blocking assignment lets the later one win.
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            reg_addr_a  <= '0;
            reg_addr_b  <= '0;
            reg_addr_wr <= '0;
            reg_wr_data <= '0;
            reg_wr_en   <= 1'b0;
            alu_sel     <= OP_ADD;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        src_b_q <= cmd_src_b;
                        dst_q   <= cmd_dst;
                        rep_cnt <= cmd_rep;
                        if (cmd_kind == CMD_ALU) begin
                            state      <= S_EXEC;
                            reg_addr_a <= cmd_src_a;
                            reg_addr_b <= cmd_src_b;
                            alu_sel    <= cmd_op;
                        end else begin
                            state <= S_WAIT_KEY;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                // reg_wr_data doubles as the result register for WRITE.
                S_EXEC: begin
                    flag_zero   <= alu_zero;
                    flag_carry  <= alu_carry;
                    state       <= S_WRITE;
                    reg_addr_wr <= dst_q;
                    reg_wr_data <= alu_result;
                    reg_wr_en   <= 1'b1;
                end

                S_WRITE: begin
                    if (rep_cnt == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        // Chained accumulate: operand A is now the destination.
                        rep_cnt    <= rep_cnt - 1'b1;
                        state      <= S_EXEC;
                        reg_addr_a <= dst_q;
                        reg_addr_b <= src_b_q;
                        alu_sel    <= op_q;
                    end
                end

                S_WAIT_KEY: begin
                    if (key_valid) begin
                        state       <= S_LOAD;
                        reg_addr_wr <= dst_q;
                        reg_wr_data <= {4'b0000, key_code};
                        reg_wr_en   <= 1'b1;
                    end else if (key_expired) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end

                S_LOAD: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
